// File: rtl/chess_tick_sched_pkg.sv
// Shared types and constants for the chess clock turn scheduler.
package chess_tick_pkg;

  typedef enum logic [2:0] {
    SCHED_IDLE  = 3'd0,
    SCHED_RUN_A = 3'd1,
    SCHED_RUN_B = 3'd2,
    SCHED_PAUSE = 3'd3,
    SCHED_OVER  = 3'd4
  } t_sched_state;

  // BCD mm:ss, [3]=m10 [2]=m1 [1]=s10 [0]=s1
  typedef logic [3:0][3:0] t_bcd_time;

  localparam t_bcd_time c_time_max = 16'h9959;

  typedef enum logic {
    BCD_DEC1  = 1'b0,
    BCD_ADD_N = 1'b1
  } t_bcd_mode;

  // Out-of-range start digits are read as 9.
  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

endpackage

// File: rtl/chess_tick_sched_if.sv
// Switch-side inputs and display-side outputs of the chess clock scheduler.
interface chess_tick_sched_if
  import chess_tick_pkg::*;
#(
  parameter int p_moves_w = 8
);
  logic [1:0][3:0]      i_init;
  logic                 i_restart;
  logic                 i_stop;
  logic                 i_player_a_press;
  logic                 i_player_b_press;
  t_bcd_time            o_player_a_time;
  t_bcd_time            o_player_b_time;
  logic                 o_player_a_turn;
  logic                 o_player_b_turn;
  logic                 o_running;
  logic                 o_player_a_flag;
  logic                 o_player_b_flag;
  logic [p_moves_w-1:0] o_moves;

  modport master (
    output i_init, i_restart, i_stop, i_player_a_press, i_player_b_press,
    input  o_player_a_time, o_player_b_time, o_player_a_turn, o_player_b_turn,
           o_running, o_player_a_flag, o_player_b_flag, o_moves
  );

  modport slave (
    input  i_init, i_restart, i_stop, i_player_a_press, i_player_b_press,
    output o_player_a_time, o_player_b_time, o_player_a_turn, o_player_b_turn,
           o_running, o_player_a_flag, o_player_b_flag, o_moves
  );
endinterface

// File: rtl/chess_tick_sched_bcd_time.sv
// Combinational BCD time unit shared by both banks: one-second decrement
// (stops at 00:00) or add of the Fischer increment (saturates at 99:59).
module chess_tick_bcd_time
  import chess_tick_pkg::*;
#(
  parameter int p_inc_sec = 2
) (
  input  t_bcd_time time_in,
  input  t_bcd_mode mode,
  output t_bcd_time result,
  output logic      zero
);
  localparam logic [3:0] c_inc_s10 = 4'(p_inc_sec / 10);
  localparam logic [3:0] c_inc_s1  = 4'(p_inc_sec % 10);

  logic [4:0] s1_sum, s10_sum, m1_sum, m10_sum;
  logic       c_s1, c_s10, c_m1;

  // Digit-serial borrow chain for dec1, carry chain for add_n.
  always_comb begin
    result  = time_in;
    zero    = (time_in == '0);
    s1_sum  = {1'b0, time_in[0]} + {1'b0, c_inc_s1};
    c_s1    = (s1_sum > 5'd9);
    s10_sum = {1'b0, time_in[1]} + {1'b0, c_inc_s10} + {4'd0, c_s1};
    c_s10   = (s10_sum > 5'd5);
    m1_sum  = {1'b0, time_in[2]} + {4'd0, c_s10};
    c_m1    = (m1_sum > 5'd9);
    m10_sum = {1'b0, time_in[3]} + {4'd0, c_m1};
    if (mode == BCD_DEC1) begin
      if (!zero) begin
        if (time_in[0] != 4'd0) result[0] = time_in[0] - 4'd1;
        else begin
          result[0] = 4'd9;
          if (time_in[1] != 4'd0) result[1] = time_in[1] - 4'd1;
          else begin
            result[1] = 4'd5;
            if (time_in[2] != 4'd0) result[2] = time_in[2] - 4'd1;
            else begin
              result[2] = 4'd9;
              result[3] = time_in[3] - 4'd1;
            end
          end
        end
      end
    end else begin
      result[0] = c_s1  ? 4'(s1_sum - 5'd10) : s1_sum[3:0];
      result[1] = c_s10 ? 4'(s10_sum - 5'd6) : s10_sum[3:0];
      result[2] = c_m1  ? 4'd0 : m1_sum[3:0];
      result[3] = m10_sum[3:0];
      if (m10_sum > 5'd9) result = c_time_max;
    end
  end
endmodule

// File: rtl/chess_tick_sched.sv
// Chess clock turn scheduler: owns both time banks, the 1 s prescaler,
// the turn FSM, Fischer increment on hand-over and the full-move counter.
module chess_tick_sched
  import chess_tick_pkg::*;
#(
  parameter int p_divider = 50_000_000,
  parameter int p_inc_sec = 2,
  parameter int p_moves_w = 8
) (
  input logic               i_clk_50m,
  input logic               i_rst,
  chess_tick_sched_if.slave bus
);
  localparam logic [2:0] ST_IDLE  = 3'(SCHED_IDLE);
  localparam logic [2:0] ST_RUN_A = 3'(SCHED_RUN_A);
  localparam logic [2:0] ST_RUN_B = 3'(SCHED_RUN_B);
  localparam logic [2:0] ST_PAUSE = 3'(SCHED_PAUSE);
  localparam logic [2:0] ST_OVER  = 3'(SCHED_OVER);

  localparam int              c_pre_w    = (p_divider > 2) ? $clog2(p_divider) : 1;
  localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(p_divider - 1);

  logic [2:0]           state, state_nx;
  logic                 side_b, side_nx;   // side held by PAUSE / OVER
  t_bcd_time            time_a, time_a_nx, time_b, time_b_nx;
  logic [c_pre_w-1:0]   pre_cnt, pre_nx;
  logic [p_moves_w-1:0] moves, moves_nx;
  logic                 flag_a, flag_a_nx, flag_b, flag_b_nx;
  logic                 turn_a, turn_b, running;

  t_bcd_time init_time, bcd_in, bcd_res;
  t_bcd_mode bcd_mode;
  logic      bcd_zero, act_b, own_press, tick;

  assign init_time = {clamp_digit(bus.i_init[1]), clamp_digit(bus.i_init[0]), 8'h00};
  assign act_b     = (state == ST_RUN_B);
  assign bcd_in    = act_b ? time_b : time_a;
  assign own_press = act_b ? bus.i_player_b_press : bus.i_player_a_press;
  assign tick      = (pre_cnt == c_pre_last);
  assign bcd_mode  = own_press ? BCD_ADD_N : BCD_DEC1;

  chess_tick_bcd_time #(.p_inc_sec(p_inc_sec)) u_bcd (
    .time_in (bcd_in),
    .mode    (bcd_mode),
    .result  (bcd_res),
    .zero    (bcd_zero)
  );

  // Next-state: restart > flag fall > stop > press > tick.
  always_comb begin
    state_nx  = state;
    side_nx   = side_b;
    time_a_nx = time_a;
    time_b_nx = time_b;
    pre_nx    = pre_cnt;
    moves_nx  = moves;
    flag_a_nx = flag_a;
    flag_b_nx = flag_b;
    if (bus.i_restart) begin
      state_nx  = ST_IDLE;
      side_nx   = 1'b0;
      time_a_nx = init_time;
      time_b_nx = init_time;
      pre_nx    = '0;
      moves_nx  = '0;
      flag_a_nx = 1'b0;
      flag_b_nx = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          pre_nx = '0;
          if (bus.i_player_a_press)      state_nx = ST_RUN_B;
          else if (bus.i_player_b_press) state_nx = ST_RUN_A;
        end
        ST_RUN_A, ST_RUN_B: begin
          if (bcd_zero) begin
            state_nx = ST_OVER;
            side_nx  = act_b;
            if (act_b) flag_b_nx = 1'b1;
            else       flag_a_nx = 1'b1;
          end else if (bus.i_stop) begin
            state_nx = ST_PAUSE;
            side_nx  = act_b;
          end else if (own_press) begin
            pre_nx   = '0;
            state_nx = act_b ? ST_RUN_A : ST_RUN_B;
            if (act_b) begin
              time_b_nx = bcd_res;
              if (moves != {p_moves_w{1'b1}}) moves_nx = moves + 1'b1;
            end else begin
              time_a_nx = bcd_res;
            end
          end else if (tick) begin
            pre_nx = '0;
            if (act_b) time_b_nx = bcd_res;
            else       time_a_nx = bcd_res;
          end else begin
            pre_nx = pre_cnt + 1'b1;
          end
        end
        ST_PAUSE: if (bus.i_stop) state_nx = side_b ? ST_RUN_B : ST_RUN_A;
        default: ;
      endcase
    end
  end

  // State, banks and decoded status outputs, all registered.
  always_ff @(posedge i_clk_50m) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      side_b  <= 1'b0;
      time_a  <= init_time;
      time_b  <= init_time;
      pre_cnt <= '0;
      moves   <= '0;
      flag_a  <= 1'b0;
      flag_b  <= 1'b0;
      turn_a  <= 1'b0;
      turn_b  <= 1'b0;
      running <= 1'b0;
    end else begin
      state   <= state_nx;
      side_b  <= side_nx;
      time_a  <= time_a_nx;
      time_b  <= time_b_nx;
      pre_cnt <= pre_nx;
      moves   <= moves_nx;
      flag_a  <= flag_a_nx;
      flag_b  <= flag_b_nx;
      turn_a  <= (state_nx == ST_RUN_A) ||
                 (((state_nx == ST_PAUSE) || (state_nx == ST_OVER)) && !side_nx);
      turn_b  <= (state_nx == ST_RUN_B) ||
                 (((state_nx == ST_PAUSE) || (state_nx == ST_OVER)) && side_nx);
      running <= (state_nx == ST_RUN_A) || (state_nx == ST_RUN_B);
    end
  end

  assign bus.o_player_a_time = time_a;
  assign bus.o_player_b_time = time_b;
  assign bus.o_player_a_turn = turn_a;
  assign bus.o_player_b_turn = turn_b;
  assign bus.o_running       = running;
  assign bus.o_player_a_flag = flag_a;
  assign bus.o_player_b_flag = flag_b;
  assign bus.o_moves         = moves;
endmodule
